fp16_mult: RTL and testbench



---
 rtl/fp16_pkg.sv | 35 +++
 rtl/fp16_mant_mul.sv | 10 +
 rtl/fp16_mult.sv | 97 +++++++++
 tb/tb_fp16_mult.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 field layout, constants and operand classification used by the multiplier.
package fp16_pkg;

    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 10;
    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 31;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_t;

    // Subnormals fall into the zero class (denormals-are-zero).
    function automatic fp_class_t class_of(input logic [15:0] v);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        fp_class_t         c;
        e = v[FRAC_W +: EXP_W];
        f = v[FRAC_W-1:0];
        if (e == '0)
            c = ZERO;
        else if (e == EXP_W'(EXP_MAX))
            c = (f == '0) ? INF : NAN;
        else
            c = NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/fp16_mant_mul.sv
// Combinational 11x11 unsigned significand multiplier producing the full 22-bit product.
module fp16_mant_mul (
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic [21:0] p
);

    assign p = {11'b0, a} * {11'b0, b};

endmodule

// File: rtl/fp16_mult.sv
// fp16 multiplier: decode, significand multiply, normalise, round-to-nearest-even,
// special-case selection and a single registered output stage.
module fp16_mult
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] x
);

    localparam logic signed [6:0] BIAS7 = 7'(EXP_BIAS);
    localparam logic signed [6:0] EMAX7 = 7'(EXP_MAX);

    fp_class_t         ca;
    fp_class_t         cb;
    logic              s;
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [FRAC_W:0]   sig_a;
    logic [FRAC_W:0]   sig_b;
    logic [21:0]       p;

    logic signed [6:0] e_norm;
    logic signed [6:0] e_final;
    logic [9:0]        mant;
    logic              guard;
    logic              sticky;
    logic [10:0]       mant_rnd;
    logic [15:0]       normal_res;
    logic [15:0]       result;

    assign ca    = class_of(a);
    assign cb    = class_of(b);
    assign s     = a[15] ^ b[15];
    assign ea    = a[FRAC_W +: EXP_W];
    assign eb    = b[FRAC_W +: EXP_W];
    assign sig_a = {1'b1, a[FRAC_W-1:0]};
    assign sig_b = {1'b1, b[FRAC_W-1:0]};

    fp16_mant_mul u_mant_mul (
        .a (sig_a),
        .b (sig_b),
        .p (p)
    );

    // Normalise on the product MSB, then round to nearest with ties to even.
    always_comb begin
        e_norm = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS7;
        if (p[21]) begin
            e_norm = e_norm + 7'sd1;
            mant   = p[20:11];
            guard  = p[10];
            sticky = |p[9:0];
        end else begin
            mant   = p[19:10];
            guard  = p[9];
            sticky = |p[8:0];
        end

        mant_rnd = {1'b0, mant} + {10'b0, guard & (sticky | mant[0])};
        e_final  = e_norm;
        if (mant_rnd[10]) begin
            e_final  = e_norm + 7'sd1;
            mant_rnd = '0;
        end

        if (e_final >= EMAX7)
            normal_res = {s, POS_INF[14:0]};
        else if (e_final <= 7'sd0)
            normal_res = {s, 15'h0};
        else
            normal_res = {s, e_final[4:0], mant_rnd[9:0]};
    end

    always_comb begin
        if (ca == NAN || cb == NAN)
            result = QNAN;
        else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF))
            result = QNAN;
        else if (ca == INF || cb == INF)
            result = {s, POS_INF[14:0]};
        else if (ca == ZERO || cb == ZERO)
            result = {s, 15'h0};
        else
            result = normal_res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            x <= 16'h0000;
        else
            x <= result;
    end

endmodule

// File: tb/tb_fp16_mult.sv
// Directed-vector bench for fp16_mult: table of hand-computed products plus reset sequences.
module tb_fp16_mult;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] x;

    int checks;
    int errors;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expect_x;
    } vec_t;

    vec_t vecs[$];

    fp16_mult dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .x   (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] ve);
        vec_t v;
        v.a        = va;
        v.b        = vb;
        v.expect_x = ve;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expect_x);
        checks++;
        if (x !== expect_x) begin
            errors++;
            $display("[TB] FAIL %s: x=%h expected=%h", name, x, expect_x);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        a      = 16'h4766;
        b      = 16'h4826;

        addVec(16'h4766, 16'h4826, 16'h53AC);
        addVec(16'h4766, 16'h01B2, 16'h0000);
        addVec(16'hC000, 16'h0000, 16'h8000);
        addVec(16'h3C01, 16'h3C01, 16'h3C02);
        addVec(16'h3C00, 16'h3C00, 16'h3C00);
        addVec(16'h7BFF, 16'h4000, 16'h7C00);
        addVec(16'h0400, 16'h3800, 16'h0000);
        addVec(16'h7C00, 16'h0000, 16'h7E00);
        addVec(16'h7E01, 16'h3C00, 16'h7E00);
        addVec(16'hFC00, 16'h4000, 16'hFC00);
        addVec(16'h3C00, 16'hBC00, 16'hBC00);
        addVec(16'h4000, 16'h4000, 16'h4400);
        addVec(16'h3E00, 16'h3E00, 16'h4080);
        addVec(16'h3E00, 16'h3C01, 16'h3E02);
        addVec(16'h3E00, 16'h3C03, 16'h3E04);
        addVec(16'h3C92, 16'h3F00, 16'h4000);
        addVec(16'h7E01, 16'h0000, 16'h7E00);
        addVec(16'h0000, 16'hFC00, 16'h7E00);
        addVec(16'h7C00, 16'hFC00, 16'hFC00);
        addVec(16'h8000, 16'h3C00, 16'h8000);

        @(posedge clk);
        #1;
        checkOutput("reset_state", 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 16'h0000);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_%h_x_%h", i, vecs[i].a, vecs[i].b), vecs[i].expect_x);
        end

        applyStimulus(16'h4766, 16'h4826);
        checkOutput("stream_before_change", 16'h53AC);
        #2;
        a = 16'h4000;
        b = 16'h4000;
        #1;
        checkOutput("inputs_between_edges", 16'h53AC);
        @(posedge clk);
        #1;
        checkOutput("next_edge_capture", 16'h4400);

        @(negedge clk);
        a = 16'h4766;
        b = 16'h4826;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("async_reset_hold", 16'h0000);
        a = 16'h3C01;
        b = 16'h3C01;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("release_no_stale", 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("first_edge_after_release", 16'h3C02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
